// File: rtl/crc_frame_rx.sv
// crc_frame_rx: serial receiver for 12-bit CRC frames.
//   Each frame is 8 data bits followed by 4 CRC bits, sent MSB first.
//   CRC-4 is recomputed over the data bits as they arrive. The completed
//   frame is held in a one-deep valid/ready output buffer.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   ser_in     serial data bit
//   ser_valid  ser_in carries a valid bit this cycle
//   sof        start of frame (qualified by ser_valid), marks frame bit 11
//   data_out   received data byte
//   crc_out    received CRC field
//   crc_ok     recomputed CRC equals received CRC field
//   out_valid  output buffer holds a frame
//   out_ready  consumer accepts the frame
//   busy       frame reception in progress
//   drop_cnt   saturating count of frames lost to backpressure
//
// state | meaning
// IDLE  | waiting for a bit with sof
// DATA  | shifting in data bits, CRC updating
// CRCF  | shifting in the received CRC field, CRC frozen
module crc_frame_rx #(
  parameter logic [3:0] POLY  = 4'b0101,
  parameter logic [3:0] INIT  = 4'b0000,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             sof,
  output logic [7:0]       data_out,
  output logic [3:0]       crc_out,
  output logic             crc_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, CRCF} state_t;

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic [7:0]       shift_q;
  logic [2:0]       crcf_q;   // first three CRC field bits; the fourth is ser_in
  logic [3:0]       crc_q;
  logic [7:0]       data_out_q;
  logic [3:0]       crc_out_q;
  logic             crc_ok_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic [3:0] crc_d;
  logic [3:0] crc_first_d;
  logic [3:0] crc_rx_d;
  logic       accept_d;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = d ^ c[3];
    return {c[2:0], 1'b0} ^ (fb ? POLY : 4'b0000);
  endfunction

  always_comb begin
    crc_d       = crc_step(crc_q, ser_in);
    crc_first_d = crc_step(INIT, ser_in);
    crc_rx_d    = {crcf_q, ser_in};
    // Buffer is free if empty or being drained on this same edge.
    accept_d    = !out_valid_q || out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= 8'd0;
      crcf_q      <= 3'd0;
      crc_q       <= INIT;
      data_out_q  <= 8'd0;
      crc_out_q   <= 4'd0;
      crc_ok_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;

      if (ser_valid) begin
        if (sof) begin
          // sof always (re)starts a frame, discarding any partial one.
          shift_q <= {7'd0, ser_in};
          crc_q   <= crc_first_d;
          cnt_q   <= 3'd1;
          state_q <= DATA;
          busy_q  <= 1'b1;
        end else begin
          case (state_q)
            DATA: begin
              shift_q <= {shift_q[6:0], ser_in};
              crc_q   <= crc_d;
              if (cnt_q == 3'd7) begin
                cnt_q   <= 3'd0;
                state_q <= CRCF;
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end
            CRCF: begin
              crcf_q <= crc_rx_d[2:0];
              if (cnt_q == 3'd3) begin
                cnt_q   <= 3'd0;
                state_q <= IDLE;
                busy_q  <= 1'b0;
                crc_q   <= INIT;
                if (accept_d) begin
                  data_out_q  <= shift_q;
                  crc_out_q   <= crc_rx_d;
                  crc_ok_q    <= (crc_q == crc_rx_d);
                  out_valid_q <= 1'b1;
                end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
                  drop_cnt_q <= drop_cnt_q + 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign data_out  = data_out_q;
  assign crc_out   = crc_out_q;
  assign crc_ok    = crc_ok_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_crc_frame_rx.sv
module tb_crc_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] data_out;
  logic [3:0] crc_out;
  logic       crc_ok;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] crc;
    logic       ok;
  } exp_t;

  exp_t exp_q[$];

  crc_frame_rx #(.POLY(4'b0101), .INIT(4'b0000), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .sof(sof),
    .data_out(data_out), .crc_out(crc_out), .crc_ok(crc_ok),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid and
  // ready are both high mid-cycle.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame: got data 0x%0h crc 0x%0h, no frame expected",
                 data_out, crc_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp("mon_data", {24'd0, data_out}, {24'd0, e.data});
        cmp("mon_crc",  {28'd0, crc_out},  {28'd0, e.crc});
        cmp("mon_ok",   {31'd0, crc_ok},   {31'd0, e.ok});
      end
    end
  end

  // All drive tasks start and end at posedge + 1.
  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    ser_in = b; ser_valid = 1'b1; sof = s;
    @(posedge clk); #1;
    ser_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] f, input int gap_max,
                            input bit rdy_last, input bit chk_lat);
    for (int i = 11; i >= 0; i--) begin
      if (i == 0) begin
        if (chk_lat) cmp("valid_before_last", {31'd0, out_valid}, 32'd0);
        if (rdy_last) out_ready = 1'b1;
      end
      send_bit(f[i], i == 11);
      if (i == 11) cmp("busy_in_frame", {31'd0, busy}, 32'd1);
      if (i == 0) begin
        cmp("busy_after_frame", {31'd0, busy}, 32'd0);
        if (chk_lat) cmp("valid_after_last", {31'd0, out_valid}, 32'd1);
      end
      if (gap_max > 0 && i != 0) repeat ($urandom_range(0, gap_max)) idle_cycle();
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [3:0] c, input logic ok);
    exp_t e;
    e.data = d; e.crc = c; e.ok = ok;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] f;
    #12;
    cmp("rst_data",  {24'd0, data_out}, 32'd0);
    cmp("rst_valid", {31'd0, out_valid}, 32'd0);
    cmp("rst_busy",  {31'd0, busy}, 32'd0);
    cmp("rst_drop",  {24'd0, drop_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    idle_cycle();

    // Back-to-back good frame, one-cycle pulse.
    push_exp(8'h80, 4'hA, 1'b1);
    send_frame(12'h80A, 0, 1'b0, 1'b1);
    idle_cycle();
    cmp("valid_pulse", {31'd0, out_valid}, 32'd0);

    // Gapped frames.
    push_exp(8'hFF, 4'hF, 1'b1);
    send_frame(12'hFFF, 3, 1'b0, 1'b0);
    push_exp(8'h01, 4'h5, 1'b1);
    send_frame(12'h015, 3, 1'b0, 1'b0);
    repeat (2) idle_cycle();
    cmp("busy_idle", {31'd0, busy}, 32'd0);

    // Corrupt CRC is still delivered, flagged.
    push_exp(8'h80, 4'hB, 1'b0);
    send_frame(12'h80B, 0, 1'b0, 1'b1);
    repeat (2) idle_cycle();

    // Backpressure: second frame dropped, third lands as the first drains.
    out_ready = 1'b0;
    push_exp(8'h80, 4'hA, 1'b1);
    send_frame(12'h80A, 0, 1'b0, 1'b0);
    send_frame(12'hFFF, 1, 1'b0, 1'b0);
    cmp("drop_one",   {24'd0, drop_cnt}, 32'd1);
    cmp("hold_data",  {24'd0, data_out}, 32'h80);
    cmp("hold_crc",   {28'd0, crc_out},  32'hA);
    cmp("hold_valid", {31'd0, out_valid}, 32'd1);
    push_exp(8'h01, 4'h5, 1'b1);
    send_frame(12'h015, 0, 1'b1, 1'b0);
    cmp("load_data", {24'd0, data_out}, 32'h01);
    cmp("drop_kept", {24'd0, drop_cnt}, 32'd1);
    repeat (2) idle_cycle();

    // sof restart after 5 bits.
    f = 12'h80A;
    for (int i = 11; i >= 7; i--) send_bit(f[i], i == 11);
    push_exp(8'hFF, 4'hF, 1'b1);
    send_frame(12'hFFF, 0, 1'b0, 1'b1);
    repeat (2) idle_cycle();
    cmp("restart_drop", {24'd0, drop_cnt}, 32'd1);
    cmp("restart_q_empty", exp_q.size(), 32'd0);

    // Reset mid-frame with a frame buffered.
    out_ready = 1'b0;
    send_frame(12'h80A, 0, 1'b0, 1'b0);
    f = 12'hFFF;
    for (int i = 11; i >= 6; i--) send_bit(f[i], i == 11);
    rst = 1'b0;
    #1;
    cmp("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    cmp("mid_rst_data",  {24'd0, data_out}, 32'd0);
    cmp("mid_rst_crc",   {28'd0, crc_out}, 32'd0);
    cmp("mid_rst_ok",    {31'd0, crc_ok}, 32'd0);
    cmp("mid_rst_busy",  {31'd0, busy}, 32'd0);
    cmp("mid_rst_drop",  {24'd0, drop_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    idle_cycle();
    push_exp(8'h01, 4'h5, 1'b1);
    send_frame(12'h015, 0, 1'b0, 1'b1);
    repeat (3) idle_cycle();
    cmp("final_q_empty", exp_q.size(), 32'd0);
    cmp("final_drop", {24'd0, drop_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc_frame_rx.md
Name: crc_frame_rx

Overview:
- Serial receive stage for 12-bit CRC frames: 8 data bits then 4 CRC bits, MSB first.
- Deserialises the bit stream and recomputes CRC-4 on the fly over the data bits.
- Presents data, received CRC and a pass/fail flag on a one-deep valid/ready output buffer.
- Consumes the serialised form of the codeword produced by the CRC transmitter stage and replaces its combinational compare with a framed, flow-controlled receiver.

Parameters:
POLY, 4'b0101, CRC-4 generator low bits (x^4+x^2+1); fixed for compatibility with the transmitter.
INIT, 4'b0000, CRC register value at start of each frame.
CNT_W, 8, width of the dropped-frame counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
ser_in  input  1  serial data bit
ser_valid  input  1  ser_in carries a valid bit this cycle
sof  input  1  start of frame; qualified by ser_valid; marks frame bit 11
data_out  output  8  received data byte
crc_out  output  4  received CRC field
crc_ok  output  1  recomputed CRC equals received CRC
out_valid  output  1  output buffer holds a frame
out_ready  input  1  consumer accepts the frame
busy  output  1  frame reception in progress
drop_cnt  output  CNT_W  saturating count of frames lost to backpressure

Behaviour:
- Reset (rst=0, asynchronous):
  - data_out=0, crc_out=0, crc_ok=0, out_valid=0, busy=0, drop_cnt=0.
  - FSM returns to IDLE; bit counter=0; CRC register=INIT.
- CRC update per data bit d, with c the 4-bit register:
  - fb = d ^ c[3]
  - c_next = {c[2:0],1'b0} ^ (fb ? POLY : 0)
- FSM states:
  - IDLE: ser_valid&&sof loads bit 11 as the first data bit, updates the CRC, sets count=1, goes to DATA. Bits without sof are ignored.
  - DATA: each ser_valid bit is shifted into the data register and updates the CRC. After the 8th data bit, go to CRCF.
  - CRCF: each ser_valid bit is shifted into the CRC field with no CRC update. On the 4th CRC bit (12th frame bit), complete the frame and return to IDLE.
- ser_valid=0 in any state: hold all state. Arbitrary gaps between bits are allowed.
- sof with ser_valid in DATA or CRCF: discard the partial frame, reinitialise the CRC to INIT, treat the bit as frame bit 11, continue in DATA with count=1.
- busy=1 in DATA and CRCF; busy=0 in IDLE.
- Frame completion, on the clock edge that samples the 12th bit:
  - If out_valid=0, or out_valid&&out_ready in the same cycle: load data_out, crc_out and crc_ok (final CRC == received field), and set out_valid=1.
  - Latency: out_valid rises one cycle after the last bit is presented.
  - If out_valid=1 and out_ready=0: drop the new frame, keep the buffer unchanged, increment drop_cnt, saturating at all-ones.
- Handshake:
  - Transfer occurs when out_valid&&out_ready.
  - With no completion in that cycle, out_valid clears next edge.
  - Outputs remain stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 has no effect.
- crc_ok=0 does not block delivery; the frame is still presented, flagged.
- Reset mid-frame: partial frame lost, buffered frame lost, all outputs at reset values.

Test Plan:
- Frame 0x80A sent back-to-back, out_ready=1 → out_valid pulses 1 cycle after bit 12; data_out=0x80, crc_out=0xA, crc_ok=1.
- Frame 0xFFF, then frame 0x015, with random ser_valid gaps → data_out=0xFF/crc_ok=1, then data_out=0x01/crc_out=0x5/crc_ok=1; busy=1 only during frames.
- Frame 0x80B (corrupt CRC) → data_out=0x80, crc_out=0xB, crc_ok=0, out_valid=1.
- out_ready held 0; send 0x80A then 0xFFF → buffer keeps 0x80A, drop_cnt=1. Raise out_ready on the cycle the third frame (0x015) completes → 0x80A transferred, 0x015 loaded, drop_cnt stays 1.
- sof re-asserted after 5 bits of a frame, followed by full frame 0xFFF → single output 0xFF, crc_ok=1, no drop.
- rst low for 1 cycle after 6 bits of a frame and while out_valid=1 → all outputs 0, busy=0. A subsequent 0x015 frame is received correctly.
